// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter: FSM states, access owner and byte-enable constants.
package HighLevelControl;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_IFETCH = 2'd1,
        ARB_DATA   = 2'd2
    } arbState;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } memOwner;

    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    // Which requester owns the memory in a given state (meaningless in ARB_IDLE).
    function automatic memOwner owner_of(input arbState s);
        return (s == ARB_DATA) ? OWNER_D : OWNER_I;
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_timeout.sv
// Busy-cycle counter with synchronous clear; tc_c is high in the cycle the count reaches its limit.
module arbTimeoutCounter #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // The current cycle is the TIMEOUT_CYCLES-th busy cycle when TIMEOUT_CYCLES-1 have already elapsed.
    assign tc_c = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !tc_c) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one instruction-fetch and one data port onto a single-outstanding memory interface,
// with anti-starvation for fetches and a busy timeout that aborts hung accesses.
module unified_mem_arbiter
    import HighLevelControl::*;
#(
    parameter int unsigned BIT_COUNT      = 32,
    parameter int unsigned MAX_D_STREAK   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 IReq,
    input  logic [BIT_COUNT-1:0] IAdr,
    output logic                 IGnt,
    output logic                 IValid,
    output logic [31:0]          IRdata,
    input  logic                 DReq,
    input  logic                 DWrite,
    input  logic [3:0]           DByteEn,
    input  logic [BIT_COUNT-1:0] DAdr,
    input  logic [31:0]          DWdata,
    output logic                 DGnt,
    output logic                 DValid,
    output logic [31:0]          DRdata,
    output logic                 MemEn,
    output logic                 MemWrite,
    output logic [3:0]           ByteEn,
    output logic [BIT_COUNT-1:0] MemAdr,
    output logic [31:0]          MemWriteData,
    input  logic [31:0]          MemReadData,
    input  logic                 MemReady,
    output logic                 MemError
);

    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);

    generate
        if (BIT_COUNT != 32 && BIT_COUNT != 64) begin : g_bad_width
            $error("unified_mem_arbiter: BIT_COUNT must be 32 or 64");
        end
    endgenerate

    arbState                 state_q,  state_d;
    logic [STREAK_W-1:0]     streak_q, streak_d;
    logic [BIT_COUNT-1:0]    adr_q,    adr_d;
    logic [31:0]             wdata_q,  wdata_d;
    logic                    write_q,  write_d;
    logic [3:0]              be_q,     be_d;
    logic                    error_q,  error_d;
    logic                    run_q,    run_d;

    logic    busy_c;
    logic    done_c;
    logic    streak_full_c;
    logic    tmo_tc_c;
    memOwner owner_c;

    arbTimeoutCounter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (reset),
        .clear  (IGnt || DGnt),
        .enable (busy_c),
        .tc_c   (tmo_tc_c)
    );

    // run_q blocks grants until the first clock edge after reset release.
    always_comb begin
        busy_c        = (state_q != ARB_IDLE);
        owner_c       = owner_of(state_q);
        streak_full_c = (streak_q == STREAK_W'(MAX_D_STREAK));
        done_c        = busy_c && (MemReady || tmo_tc_c);

        DGnt = 1'b0;
        IGnt = 1'b0;
        if (state_q == ARB_IDLE && run_q) begin
            if (DReq && !(IReq && streak_full_c)) begin
                DGnt = 1'b1;
            end else if (IReq) begin
                IGnt = 1'b1;
            end
        end

        state_d = state_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        be_d    = be_q;
        if (DGnt) begin
            state_d = ARB_DATA;
            adr_d   = DAdr;
            wdata_d = DWdata;
            write_d = DWrite;
            be_d    = DWrite ? DByteEn : BE_ALL;
        end else if (IGnt) begin
            state_d = ARB_IFETCH;
            adr_d   = IAdr;
            write_d = 1'b0;
            be_d    = BE_ALL;
        end else if (done_c) begin
            state_d = ARB_IDLE;
        end

        // Counts data grants that overtook a waiting fetch.
        streak_d = streak_q;
        if (!IReq || IGnt) begin
            streak_d = '0;
        end else if (DGnt && !streak_full_c) begin
            streak_d = streak_q + STREAK_W'(1);
        end

        error_d = error_q || (done_c && !MemReady);
        run_d   = 1'b1;
    end

    // Memory and completion outputs, all qualified by the registered state.
    always_comb begin
        MemEn        = busy_c;
        MemWrite     = (state_q == ARB_DATA) && write_q;
        ByteEn       = busy_c ? be_q : BE_NONE;
        MemAdr       = adr_q;
        MemWriteData = wdata_q;
        MemError     = error_q;

        IValid = done_c && (owner_c == OWNER_I);
        DValid = done_c && (owner_c == OWNER_D);
        IRdata = (IValid && MemReady) ? MemReadData : 32'h0;
        DRdata = (DValid && MemReady && !write_q) ? MemReadData : 32'h0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ARB_IDLE;
            streak_q <= '0;
            adr_q    <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            be_q     <= BE_NONE;
            error_q  <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            be_q     <= be_d;
            error_q  <= error_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: expected grants and completions are queued by the stimulus and checked by a monitor.
module tb_unified_mem_arbiter;

    localparam int BOUND = 300;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        IReq = 1'b0;
    logic [31:0] IAdr = '0;
    logic        IGnt, IValid;
    logic [31:0] IRdata;
    logic        DReq = 1'b0;
    logic        DWrite = 1'b0;
    logic [3:0]  DByteEn = '0;
    logic [31:0] DAdr = '0;
    logic [31:0] DWdata = '0;
    logic        DGnt, DValid;
    logic [31:0] DRdata;
    logic        MemEn, MemWrite;
    logic [3:0]  ByteEn;
    logic [31:0] MemAdr, MemWriteData;
    logic [31:0] MemReadData;
    logic        MemReady = 1'b0;
    logic        MemError;

    unified_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .IReq(IReq), .IAdr(IAdr), .IGnt(IGnt), .IValid(IValid), .IRdata(IRdata),
        .DReq(DReq), .DWrite(DWrite), .DByteEn(DByteEn), .DAdr(DAdr), .DWdata(DWdata),
        .DGnt(DGnt), .DValid(DValid), .DRdata(DRdata),
        .MemEn(MemEn), .MemWrite(MemWrite), .ByteEn(ByteEn), .MemAdr(MemAdr),
        .MemWriteData(MemWriteData), .MemReadData(MemReadData), .MemReady(MemReady),
        .MemError(MemError)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic [31:0] adr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          lat;
    } resp_t;

    resp_t exp_q[$];
    logic  exp_g[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    gnt_cyc = 0;
    int    gcount = 0;

    // Memory model: MemReady on busy cycle ready_at (0 = never); idle_ready drives MemReady while idle.
    int          ready_at = 1;
    logic        idle_ready = 1'b0;
    int          bcnt = 0;
    logic [31:0] rdata_cfg = '0;
    assign MemReadData = rdata_cfg;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always begin
        @(posedge clk);
        #1;
        if (MemEn) bcnt++;
        else bcnt = 0;
        MemReady = MemEn ? (ready_at != 0 && bcnt == ready_at) : idle_ready;
    end

    // Monitor: pops expectations whenever the DUT grants or completes.
    always @(negedge clk) begin
        resp_t r;
        logic  g;
        if (IGnt && DGnt) chk("one_grant", 2'b11, 2'b01);
        if (IGnt || DGnt) begin
            if (exp_g.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_grant actual=%0d required=none", DGnt);
            end else begin
                g = exp_g.pop_front();
                chk("grant_owner", 64'(DGnt), 64'(g));
            end
            gnt_cyc = cyc;
            gcount++;
        end
        if (IValid || DValid) begin
            if (IValid && DValid) chk("one_valid", 2'b11, 2'b01);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid actual=%0d required=none", DValid);
            end else begin
                r = exp_q.pop_front();
                chk("valid_owner", 64'(DValid), 64'(r.is_d));
                chk("rdata", 64'(DValid ? DRdata : IRdata), 64'(r.rdata));
                chk("mem_adr", 64'(MemAdr), 64'(r.adr));
                chk("mem_write", 64'(MemWrite), 64'(r.wr));
                chk("byte_en", 64'(ByteEn), 64'(r.be));
                chk("mem_en", 64'(MemEn), 64'h1);
                if (r.wr) chk("mem_wdata", 64'(MemWriteData), 64'(r.wdata));
                chk("latency", 64'(cyc - gnt_cyc), 64'(r.lat));
            end
        end
    end

    task automatic do_i(input logic [31:0] adr, output int n);
        n = 0;
        IReq = 1'b1; IAdr = adr;
        @(negedge clk);
        while (!IGnt && n < BOUND) begin @(negedge clk); n++; end
        if (!IGnt) begin checks++; errors++; $display("FAIL i_grant_timeout actual=0 required=1"); end
        @(posedge clk); #1;
        IReq = 1'b0;
    endtask

    task automatic do_d(input logic wr, input logic [3:0] be, input logic [31:0] adr,
                        input logic [31:0] wd, output int n);
        n = 0;
        DReq = 1'b1; DWrite = wr; DByteEn = be; DAdr = adr; DWdata = wd;
        @(negedge clk);
        while (!DGnt && n < BOUND) begin @(negedge clk); n++; end
        if (!DGnt) begin checks++; errors++; $display("FAIL d_grant_timeout actual=0 required=1"); end
        @(posedge clk); #1;
        DReq = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < BOUND) begin @(negedge clk); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_drain actual=%0d required=0", name, exp_q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n, n2;

        // Reset values
        #12;
        chk("rst_mem_en", 64'(MemEn), 0);
        chk("rst_mem_write", 64'(MemWrite), 0);
        chk("rst_byte_en", 64'(ByteEn), 0);
        chk("rst_mem_adr", 64'(MemAdr), 0);
        chk("rst_mem_wdata", 64'(MemWriteData), 0);
        chk("rst_mem_error", 64'(MemError), 0);
        chk("rst_valids", 64'({IValid, DValid}), 0);
        chk("rst_rdata", 64'({IRdata, DRdata}), 0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Lone fetch; MemReady high while idle must be ignored
        ready_at = 2; idle_ready = 1'b1; rdata_cfg = 32'h0050_0093;
        exp_g.push_back(1'b0);
        exp_q.push_back('{1'b0, 32'h0050_0093, 32'h100, 1'b0, 4'hF, 32'h0, 2});
        do_i(32'h100, n);
        idle_ready = 1'b0;
        wait_idle("fetch");

        // Simultaneous store and fetch: data first
        ready_at = 1; rdata_cfg = 32'h1234_5678;
        exp_g.push_back(1'b1); exp_g.push_back(1'b0);
        exp_q.push_back('{1'b1, 32'h0, 32'h2000, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1});
        exp_q.push_back('{1'b0, 32'h1234_5678, 32'h300, 1'b0, 4'hF, 32'h0, 1});
        fork
            do_d(1'b1, 4'b0011, 32'h2000, 32'hDEAD_BEEF, n);
            do_i(32'h300, n2);
        join
        wait_idle("simul");

        // Starvation: D,D,D,D,I twice
        rdata_cfg = 32'h1111_0000;
        for (int k = 0; k < 10; k++) begin
            exp_g.push_back((k % 5) != 4);
            if ((k % 5) != 4)
                exp_q.push_back('{1'b1, 32'h1111_0000, 32'h40, 1'b0, 4'hF, 32'h0, 1});
            else
                exp_q.push_back('{1'b0, 32'h1111_0000, 32'h80, 1'b0, 4'hF, 32'h0, 1});
        end
        gcount = 0;
        IReq = 1'b1; IAdr = 32'h80;
        DReq = 1'b1; DWrite = 1'b0; DByteEn = 4'h0; DAdr = 32'h40;
        n = 0;
        while (gcount < 10 && n < BOUND) begin @(posedge clk); #1; n++; end
        chk("starve_grants", 64'(gcount), 10);
        IReq = 1'b0; DReq = 1'b0;
        wait_idle("starve");
        chk("no_error_yet", 64'(MemError), 0);

        // Timeout on a hung load, then a fetch still completes
        ready_at = 0; rdata_cfg = 32'hCAFE_F00D;
        exp_g.push_back(1'b1);
        exp_q.push_back('{1'b1, 32'h0, 32'h500, 1'b0, 4'hF, 32'h0, 64});
        do_d(1'b0, 4'h0, 32'h500, 32'h0, n);
        wait_idle("timeout");
        chk("mem_error_set", 64'(MemError), 1);
        ready_at = 1; rdata_cfg = 32'h0BAD_F00D;
        exp_g.push_back(1'b0);
        exp_q.push_back('{1'b0, 32'h0BAD_F00D, 32'h600, 1'b0, 4'hF, 32'h0, 1});
        do_i(32'h600, n);
        wait_idle("post_timeout");
        chk("mem_error_sticky", 64'(MemError), 1);

        // Reset in the middle of a data access: no completion
        ready_at = 0;
        exp_g.push_back(1'b1);
        do_d(1'b0, 4'h0, 32'h900, 32'h0, n);
        repeat (2) @(posedge clk);
        #3; reset = 1'b0; #1;
        chk("mid_rst_mem_en", 64'(MemEn), 0);
        chk("mid_rst_mem_adr", 64'(MemAdr), 0);
        chk("mid_rst_byte_en", 64'(ByteEn), 0);
        chk("mid_rst_mem_wdata", 64'(MemWriteData), 0);
        chk("mid_rst_dvalid", 64'(DValid), 0);
        chk("mid_rst_mem_error", 64'(MemError), 0);
        IReq = 1'b1; #1;
        chk("mid_rst_ignt", 64'(IGnt), 0);
        IReq = 1'b0;
        @(negedge clk); @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        ready_at = 2; rdata_cfg = 32'h7777_7777;
        exp_g.push_back(1'b1);
        exp_q.push_back('{1'b1, 32'h0, 32'hA00, 1'b1, 4'b1100, 32'hCAFE_BABE, 2});
        do_d(1'b1, 4'b1100, 32'hA00, 32'hCAFE_BABE, n);
        chk("gnt_after_release", 64'(n), 0);
        wait_idle("post_reset");

        repeat (3) @(posedge clk);
        chk("grants_drained", 64'(exp_g.size()), 0);
        chk("resps_drained", 64'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
